m_div_iterative: RTL and testbench

Parametrised iterative integer divider for the RISC-V M-extension datapath, executing DIV, DIVU, REM and REMU with a start/done handshake. It replaces the fixed 32-bit, one-bit-per-cycle divide sequencing with a configurable word width and radix, and it is self-sequenced by its own FSM. It also adds an abort input and single-cycle handling of the divide-by-zero and signed-overflow corner cases. It sits beside the multiplier in the M unit and is driven directly from the decoded funct3 and the register-file operands.

---
 rtl/m_div_iterative_if.sv | 32 +++
 rtl/m_div_iterative.sv | 163 ++++++++++++++++
 tb/tb_m_div_iterative.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/m_div_iterative_if.sv
// ============================================================================
// Module      : m_div_iterative_if
// Description : Start/done handshake and operand/result bundle for the
//               iterative M-extension divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface m_div_iterative_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic            kill;
    logic [1:0]      op;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, kill, op, rs1, rs2,
        input  busy, done, result
    );

    modport slave (
        input  start, kill, op, rs1, rs2,
        output busy, done, result
    );
endinterface

`default_nettype wire

// File: rtl/m_div_iterative.sv
// ============================================================================
// Module      : m_div_iterative
// Description : Radix-configurable restoring divider for DIV/DIVU/REM/REMU.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module m_div_iterative #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  wire logic          clk,
    input  wire logic          reset,
    m_div_iterative_if.slave   bus
);

    localparam int N  = XLEN / BITS_PER_CYCLE;
    localparam int CW = $clog2(N) + 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DIVIDE = 2'd1;
    localparam logic [1:0] S_FIXUP  = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [XLEN-1:0] C_MIN  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] C_ONES = {XLEN{1'b1}};
    localparam logic [CW-1:0]   C_LAST = CW'(N - 1);

    if (!((BITS_PER_CYCLE == 1) || (BITS_PER_CYCLE == 2) ||
          (BITS_PER_CYCLE == 4) || (BITS_PER_CYCLE == 8)) ||
        ((XLEN % BITS_PER_CYCLE) != 0)) begin : g_bad_param
        $error("m_div_iterative: illegal XLEN/BITS_PER_CYCLE combination");
    end

    logic [1:0]      r_state;
    logic [1:0]      w_next_state;
    logic [CW-1:0]   r_cnt;
    logic            r_sel_rem;
    logic            r_neg_q;
    logic            r_neg_r;
    logic [XLEN-1:0] r_divisor;
    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_result;

    logic            w_accept;
    logic            w_signed;
    logic            w_s1;
    logic            w_s2;
    logic [XLEN-1:0] w_mag1;
    logic [XLEN-1:0] w_mag2;
    logic            w_div0;
    logic            w_ovf;
    logic            w_special;
    logic [XLEN-1:0] w_special_res;
    logic [XLEN-1:0] w_p;
    logic [XLEN-1:0] w_q;
    logic [XLEN:0]   w_pext;
    logic [XLEN:0]   w_t;
    logic [XLEN-1:0] w_quo_fix;
    logic [XLEN-1:0] w_rem_fix;

    // Operand decode; op[0]=0 selects the signed variants.
    assign w_accept  = bus.start && !bus.kill && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_signed  = ~bus.op[0];
    assign w_s1      = w_signed & bus.rs1[XLEN-1];
    assign w_s2      = w_signed & bus.rs2[XLEN-1];
    assign w_mag1    = w_s1 ? -bus.rs1 : bus.rs1;
    assign w_mag2    = w_s2 ? -bus.rs2 : bus.rs2;
    assign w_div0    = (bus.rs2 == '0);
    assign w_ovf     = w_signed && (bus.rs1 == C_MIN) && (bus.rs2 == C_ONES);
    assign w_special = w_div0 || w_ovf;
    assign w_special_res = w_div0 ? (bus.op[1] ? bus.rs1 : C_ONES)
                                  : (bus.op[1] ? '0      : C_MIN);

    // BITS_PER_CYCLE chained restoring steps; r_quo shifts dividend out and quotient in.
    always_comb begin
        w_p    = r_rem;
        w_q    = r_quo;
        w_pext = '0;
        w_t    = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            w_pext = {w_p, w_q[XLEN-1]};
            w_q    = {w_q[XLEN-2:0], 1'b0};
            w_t    = w_pext - {1'b0, r_divisor};
            if (!w_t[XLEN]) begin
                w_p    = w_t[XLEN-1:0];
                w_q[0] = 1'b1;
            end else begin
                w_p    = w_pext[XLEN-1:0];
            end
        end
    end

    assign w_quo_fix = r_neg_q ? -r_quo : r_quo;
    assign w_rem_fix = r_neg_r ? -r_rem : r_rem;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_accept) begin
                    w_next_state = w_special ? S_DONE : S_DIVIDE;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_DIVIDE: w_next_state = (r_cnt == C_LAST) ? S_FIXUP : S_DIVIDE;
            S_FIXUP:  w_next_state = S_DONE;
            default:  w_next_state = S_IDLE;
        endcase
        if (bus.kill) begin
            w_next_state = S_IDLE;
        end
    end

    always_comb begin
        bus.busy   = (r_state == S_DIVIDE) || (r_state == S_FIXUP);
        bus.done   = (r_state == S_DONE);
        bus.result = r_result;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_sel_rem <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_divisor <= '0;
            r_quo     <= '0;
            r_rem     <= '0;
            r_result  <= '0;
        end else if (w_accept) begin
            r_cnt     <= '0;
            r_sel_rem <= bus.op[1];
            r_neg_q   <= w_s1 ^ w_s2;
            r_neg_r   <= w_s1;
            r_divisor <= w_mag2;
            r_quo     <= w_mag1;
            r_rem     <= '0;
            if (w_special) begin
                r_result <= w_special_res;
            end
        end else if (!bus.kill && (r_state == S_DIVIDE)) begin
            r_cnt <= r_cnt + CW'(1);
            r_quo <= w_q;
            r_rem <= w_p;
        end else if (!bus.kill && (r_state == S_FIXUP)) begin
            r_result <= r_sel_rem ? w_rem_fix : w_quo_fix;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_m_div_iterative.sv
// ============================================================================
// Module      : tb_m_div_iterative
// Description : Directed vector bench for m_div_iterative (32/1 and 64/4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_m_div_iterative;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [7:0]  lat;
    } vec_t;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_miss;
    logic [31:0] last_res32;
    logic [63:0] last_res64;
    vec_t vecs [17];

    m_div_iterative_if #(.XLEN(32)) if32 ();
    m_div_iterative_if #(.XLEN(64)) if64 ();

    m_div_iterative #(.XLEN(32), .BITS_PER_CYCLE(1)) u_dut32 (
        .clk   (clk),
        .reset (reset),
        .bus   (if32.slave)
    );

    m_div_iterative #(.XLEN(64), .BITS_PER_CYCLE(4)) u_dut64 (
        .clk   (clk),
        .reset (reset),
        .bus   (if64.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int id, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s [%0d]: got 0x%0h, expected 0x%0h", nm, id, act, exp);
        end
    endtask

    // Issue one op, scramble inputs after acceptance, then wait for done.
    task automatic run32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat, input int id);
        int   cyc;
        int   nbusy;
        logic held;
        if32.start = 1'b1;
        if32.op    = op;
        if32.rs1   = a;
        if32.rs2   = b;
        tick();
        if32.start = 1'b0;
        if32.op    = 2'($urandom);
        if32.rs1   = $urandom;
        if32.rs2   = $urandom;
        cyc   = 1;
        nbusy = 0;
        held  = 1'b1;
        while ((if32.done !== 1'b1) && (cyc < 100)) begin
            if (if32.busy === 1'b1) nbusy++;
            if (if32.result !== last_res32) held = 1'b0;
            tick();
            cyc++;
        end
        chk("latency32", id, 64'(cyc), 64'(lat));
        chk("busy_cycles32", id, 64'(nbusy), 64'(lat - 1));
        chk("result_hold32", id, {63'd0, held}, 64'd1);
        chk("result32", id, {32'd0, if32.result}, {32'd0, exp});
        last_res32 = exp;
    endtask

    task automatic run64(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp, input int lat, input int id);
        int cyc;
        if64.start = 1'b1;
        if64.op    = op;
        if64.rs1   = a;
        if64.rs2   = b;
        tick();
        if64.start = 1'b0;
        if64.rs1   = {$urandom, $urandom};
        if64.rs2   = {$urandom, $urandom};
        cyc = 1;
        while ((if64.done !== 1'b1) && (cyc < 100)) begin
            tick();
            cyc++;
        end
        chk("latency64", id, 64'(cyc), 64'(lat));
        chk("result64", id, if64.result, exp);
        last_res64 = exp;
    endtask

    initial begin
        int ndone;
        clk        = 1'b0;
        reset      = 1'b1;
        n_vec      = 0;
        n_miss     = 0;
        last_res32 = '0;
        last_res64 = '0;
        if32.start = 1'b0; if32.kill = 1'b0; if32.op = '0; if32.rs1 = '0; if32.rs2 = '0;
        if64.start = 1'b0; if64.kill = 1'b0; if64.op = '0; if64.rs1 = '0; if64.rs2 = '0;

        vecs[0]  = '{OP_DIVU, 32'd100,        32'd7,          32'd14,         8'd34};
        vecs[1]  = '{OP_REMU, 32'd100,        32'd7,          32'd2,          8'd34};
        vecs[2]  = '{OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  8'd34};
        vecs[3]  = '{OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  8'd34};
        vecs[4]  = '{OP_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          8'd34};
        vecs[5]  = '{OP_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  8'd34};
        vecs[6]  = '{OP_DIV,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         8'd34};
        vecs[7]  = '{OP_REM,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  8'd34};
        vecs[8]  = '{OP_DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF,  8'd1};
        vecs[9]  = '{OP_REM,  32'h8000_0005,  32'd0,          32'h8000_0005,  8'd1};
        vecs[10] = '{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  8'd1};
        vecs[11] = '{OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          8'd1};
        vecs[12] = '{OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          8'd34};
        vecs[13] = '{OP_REMU, 32'hFFFF_FFFF,  32'd10,         32'd5,          8'd34};
        vecs[14] = '{OP_DIVU, 32'hFFFF_FFFF,  32'd10,         32'h1999_9999,  8'd34};
        vecs[15] = '{OP_DIV,  32'd0,          32'd0,          32'hFFFF_FFFF,  8'd1};
        vecs[16] = '{OP_REMU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  8'd34};

        repeat (2) tick();
        reset = 1'b0;
        chk("reset_busy32", 0, {63'd0, if32.busy}, 64'd0);
        chk("reset_done32", 0, {63'd0, if32.done}, 64'd0);
        chk("reset_result32", 0, {32'd0, if32.result}, 64'd0);
        chk("reset_busy64", 0, {63'd0, if64.busy}, 64'd0);
        chk("reset_result64", 0, if64.result, 64'd0);

        // Consecutive calls start in the previous DONE cycle (back-to-back).
        for (int i = 0; i < 17; i++) begin
            run32(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, int'(vecs[i].lat), i);
        end
        tick();
        chk("done_one_cycle", 0, {63'd0, if32.done}, 64'd0);

        // Abort ten cycles in, with an ignored start pulsed while busy.
        if32.start = 1'b1; if32.op = OP_DIVU; if32.rs1 = 32'd100; if32.rs2 = 32'd7;
        tick();
        if32.start = 1'b0;
        repeat (4) tick();
        if32.start = 1'b1; if32.op = OP_DIVU; if32.rs1 = 32'd5; if32.rs2 = 32'd0;
        tick();
        if32.start = 1'b0;
        chk("ignored_start_busy", 0, {63'd0, if32.busy}, 64'd1);
        chk("ignored_start_done", 0, {63'd0, if32.done}, 64'd0);
        repeat (4) tick();
        if32.kill = 1'b1;
        tick();
        if32.kill = 1'b0;
        chk("kill_busy", 0, {63'd0, if32.busy}, 64'd0);
        chk("kill_done", 0, {63'd0, if32.done}, 64'd0);
        chk("kill_result", 0, {32'd0, if32.result}, {32'd0, last_res32});
        ndone = 0;
        repeat (40) begin
            tick();
            if (if32.done === 1'b1) ndone++;
        end
        chk("kill_no_done", 0, 64'(ndone), 64'd0);

        // Kill in the same cycle as a start discards the start.
        if32.start = 1'b1; if32.kill = 1'b1; if32.op = OP_DIVU; if32.rs1 = 32'd5; if32.rs2 = 32'd0;
        tick();
        if32.start = 1'b0; if32.kill = 1'b0;
        chk("kill_start_done", 0, {63'd0, if32.done}, 64'd0);
        chk("kill_start_busy", 0, {63'd0, if32.busy}, 64'd0);
        chk("kill_start_result", 0, {32'd0, if32.result}, {32'd0, last_res32});

        run32(OP_DIVU, 32'd1000, 32'd10, 32'd100, 34, 100);

        run64(OP_DIVU, 64'h8000_0000_0000_0000, 64'd3, 64'h2AAA_AAAA_AAAA_AAAA, 18, 200);
        run64(OP_REM,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 18, 201);
        run64(OP_DIVU, 64'd77, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 202);
        tick();

        // Asynchronous reset in the middle of DIVIDE.
        if32.start = 1'b1; if32.op = OP_DIVU; if32.rs1 = 32'd100; if32.rs2 = 32'd7;
        tick();
        if32.start = 1'b0;
        repeat (5) tick();
        #2 reset = 1'b1;
        #1;
        chk("async_reset_busy", 0, {63'd0, if32.busy}, 64'd0);
        chk("async_reset_done", 0, {63'd0, if32.done}, 64'd0);
        chk("async_reset_result", 0, {32'd0, if32.result}, 64'd0);
        tick();
        reset = 1'b0;
        ndone = 0;
        repeat (40) begin
            tick();
            if (if32.done === 1'b1) ndone++;
        end
        chk("reset_no_done", 0, 64'(ndone), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire
